// File: rtl/mc_trap_ctrl.sv
// Interrupt / exception controller for the multi-cycle CPU.
// Latches and prioritises irq sources, traps on ALU overflow, redirects the
// PC to the handler vector and back to the saved EPC on eret.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | normal execution, watching for overflow / eligible irq
// S_TRAP    | one cycle: redirect PC to HANDLER_ADDR
// S_HANDLER | handler running, no nesting, eret ends it
// S_RETURN  | one cycle: redirect PC to saved EPC
module mc_trap_ctrl #(
    parameter int          NUM_IRQ      = 4,
    parameter bit          EDGE_MODE    = 1'b1,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               overflow,
    input  logic               ovf_valid,
    input  logic               inst_boundary,
    input  logic [31:0]        pc_current,
    input  logic               eret,
    input  logic               gie_we,
    input  logic               gie_wdata,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic [31:0]        epc_out,
    output logic [7:0]         cause_out,
    output logic [NUM_IRQ-1:0] pending_out,
    output logic [NUM_IRQ-1:0] int_ack,
    output logic               in_handler,
    output logic               fatal
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRAP    = 2'd1,
        S_HANDLER = 2'd2,
        S_RETURN  = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic               gie_q;
    logic [NUM_IRQ-1:0] mask_q;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pending_q;
    logic [31:0]        epc_q;
    logic [7:0]         cause_q;
    logic               fatal_q;

    logic [NUM_IRQ-1:0] pending_eff;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] winner_oh;
    logic [6:0]         winner_idx;
    logic               ovf_hit;
    logic               take_ovf;
    logic               take_irq;
    logic               set_fatal;

    // In level mode the raw source is the pending state; the edge latch is then unused.
    assign pending_eff = EDGE_MODE ? pending_q : irq_in;
    assign eligible    = pending_eff & mask_q & {NUM_IRQ{gie_q}};
    // Isolate the lowest set bit: lowest index has highest priority.
    assign winner_oh   = eligible & (~eligible + 1'b1);
    assign ovf_hit     = ovf_valid & overflow;

    // Binary index of the lowest eligible source for the cause register.
    always_comb begin
        winner_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner_idx = 7'(i);
            end
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        state_n        = state_q;
        take_ovf       = 1'b0;
        take_irq       = 1'b0;
        set_fatal      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = HANDLER_ADDR;
        int_ack        = '0;
        in_handler     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ovf_hit) begin
                    take_ovf = 1'b1;
                    state_n  = S_TRAP;
                end else if (inst_boundary && (eligible != '0)) begin
                    take_irq = 1'b1;
                    int_ack  = winner_oh;
                    state_n  = S_TRAP;
                end
            end
            S_TRAP: begin
                redirect_valid = 1'b1;
                state_n        = S_HANDLER;
            end
            S_HANDLER: begin
                in_handler = 1'b1;
                set_fatal  = ovf_hit;
                if (eret) begin
                    state_n = S_RETURN;
                end
            end
            S_RETURN: begin
                redirect_valid = 1'b1;
                redirect_pc    = epc_q;
                state_n        = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Software-visible enables, writable in any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gie_q  <= 1'b0;
            mask_q <= '0;
        end else begin
            if (gie_we) begin
                gie_q <= gie_wdata;
            end
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
        end
    end

    // Edge detector and pending latch; a new edge wins over a same-cycle ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            prev_q    <= irq_in;
            pending_q <= (pending_q & ~int_ack) | (irq_in & ~prev_q);
        end
    end

    // Trap bookkeeping: EPC, cause and the sticky nested-overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc_q   <= '0;
            cause_q <= '0;
            fatal_q <= 1'b0;
        end else begin
            if (take_ovf) begin
                // PC was already incremented when the ALU op executes.
                epc_q   <= pc_current - 32'd4;
                cause_q <= 8'h80;
            end else if (take_irq) begin
                epc_q   <= pc_current;
                cause_q <= {1'b0, winner_idx};
            end
            if (set_fatal) begin
                fatal_q <= 1'b1;
            end
        end
    end

    assign epc_out     = epc_q;
    assign cause_out   = cause_q;
    assign pending_out = pending_eff;
    assign fatal       = fatal_q;

endmodule

// File: tb/tb_mc_trap_ctrl.sv
// Bench for mc_trap_ctrl: an edge-mode and a level-mode instance share all
// inputs; directed scenarios plus a randomized run against a behavioural model.
module tb_mc_trap_ctrl;

    localparam logic [31:0] HADDR = 32'h0000_0100;
    localparam int PH_IDLE = 0, PH_TRAP = 1, PH_HANDLER = 2, PH_RETURN = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq;
    logic        ovf, ovf_v, ib, eret, gie_we, gie_wd, mask_we;
    logic [31:0] pc;
    logic [3:0]  mask_wd;

    logic        rv   [2];
    logic [31:0] rpc  [2];
    logic [31:0] epc  [2];
    logic [7:0]  cause[2];
    logic [3:0]  pend [2];
    logic [3:0]  ack  [2];
    logic        inh  [2];
    logic        fat  [2];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance (0 = edge mode, 1 = level mode)
    logic        m_gie  [2];
    logic [3:0]  m_mask [2];
    logic [3:0]  m_pend [2];
    logic [3:0]  m_prev [2];
    logic [31:0] m_epc  [2];
    logic [7:0]  m_cause[2];
    logic        m_fatal[2];
    int          m_ph   [2];

    always #5 clk = ~clk;

    mc_trap_ctrl #(.NUM_IRQ(4), .EDGE_MODE(1'b1), .HANDLER_ADDR(HADDR)) u_edge (
        .clk(clk), .reset(rst), .irq_in(irq), .overflow(ovf), .ovf_valid(ovf_v),
        .inst_boundary(ib), .pc_current(pc), .eret(eret), .gie_we(gie_we),
        .gie_wdata(gie_wd), .mask_we(mask_we), .mask_wdata(mask_wd),
        .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .epc_out(epc[0]),
        .cause_out(cause[0]), .pending_out(pend[0]), .int_ack(ack[0]),
        .in_handler(inh[0]), .fatal(fat[0]));

    mc_trap_ctrl #(.NUM_IRQ(4), .EDGE_MODE(1'b0), .HANDLER_ADDR(HADDR)) u_level (
        .clk(clk), .reset(rst), .irq_in(irq), .overflow(ovf), .ovf_valid(ovf_v),
        .inst_boundary(ib), .pc_current(pc), .eret(eret), .gie_we(gie_we),
        .gie_wdata(gie_wd), .mask_we(mask_we), .mask_wdata(mask_wd),
        .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .epc_out(epc[1]),
        .cause_out(cause[1]), .pending_out(pend[1]), .int_ack(ack[1]),
        .in_handler(inh[1]), .fatal(fat[1]));

    // ---------------- behavioural reference model ----------------
    function automatic logic [3:0] view_pend(int k);
        if (k == 0) return m_pend[0];
        return irq;
    endfunction

    function automatic logic [3:0] eligible_of(int k);
        return view_pend(k) & m_mask[k] & (m_gie[k] ? 4'hF : 4'h0);
    endfunction

    function automatic int lowest(logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] exp_ack(int k);
        if (m_ph[k] == PH_IDLE && !(ovf_v && ovf) && ib && eligible_of(k) != 4'h0)
            return 4'(1 << lowest(eligible_of(k)));
        return 4'h0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_gie[k] = 1'b0; m_mask[k] = 4'h0; m_pend[k] = 4'h0; m_prev[k] = 4'h0;
            m_epc[k] = 32'h0; m_cause[k] = 8'h0; m_fatal[k] = 1'b0; m_ph[k] = PH_IDLE;
        end
    endtask

    task automatic model_update(int k);
        logic [3:0] a;
        int w;
        a = exp_ack(k);
        w = lowest(eligible_of(k));
        case (m_ph[k])
            PH_IDLE: begin
                if (ovf_v && ovf) begin
                    m_epc[k] = pc - 32'd4; m_cause[k] = 8'h80; m_ph[k] = PH_TRAP;
                end else if (a != 4'h0) begin
                    m_epc[k] = pc; m_cause[k] = 8'(w); m_ph[k] = PH_TRAP;
                end
            end
            PH_TRAP:    m_ph[k] = PH_HANDLER;
            PH_HANDLER: begin
                if (ovf_v && ovf) m_fatal[k] = 1'b1;
                if (eret) m_ph[k] = PH_RETURN;
            end
            default:    m_ph[k] = PH_IDLE;
        endcase
        if (k == 0) begin
            m_pend[0] = (m_pend[0] & ~a) | (irq & ~m_prev[0]);
            m_prev[0] = irq;
        end
        if (gie_we)  m_gie[k]  = gie_wd;
        if (mask_we) m_mask[k] = mask_wd;
    endtask

    // Advance one clock; inputs are stable, model follows the same edge.
    task automatic step();
        #1;
        if (!rst) model_reset();
        else begin
            model_update(0);
            model_update(1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ovf = 0; ovf_v = 0; ib = 0; eret = 0; gie_we = 0; gie_wd = 0;
        mask_we = 0; mask_wd = 4'h0;
    endtask

    task automatic write_gie(logic v);
        gie_we = 1; gie_wd = v; step(); gie_we = 0;
    endtask

    task automatic write_mask(logic [3:0] v);
        mask_we = 1; mask_wd = v; step(); mask_we = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 0; irq = 4'h0; pc = 32'h0; idle_inputs(); model_reset();
        #2;
        n_checks++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL reset_rv actual=%b required=0", rv[0]); end
        n_checks++; if (rpc[0] !== HADDR) begin n_fail++; $display("FAIL reset_rpc actual=%h required=%h", rpc[0], HADDR); end
        n_checks++; if (epc[0] !== 32'h0 || cause[0] !== 8'h0) begin n_fail++; $display("FAIL reset_epc_cause actual=%h/%h required=0/0", epc[0], cause[0]); end
        n_checks++; if (pend[0] !== 4'h0 || ack[0] !== 4'h0 || inh[0] !== 1'b0 || fat[0] !== 1'b0)
            begin n_fail++; $display("FAIL reset_misc actual=%b/%b/%b/%b required=0", pend[0], ack[0], inh[0], fat[0]); end
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_wrap();
        eret = 1; step(); eret = 0; #1;
        n_checks++; if (rv[0] !== 1'b0 || inh[0] !== 1'b0) begin n_fail++; $display("FAIL eret_idle actual=%b/%b required=0/0", rv[0], inh[0]); end
        ovf_v = 1; ovf = 1; pc = 32'h0; step(); ovf_v = 0; ovf = 0; #1;
        n_checks++; if (epc[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_epc actual=%h required=fffffffc", epc[0]); end
        n_checks++; if (rv[0] !== 1'b1 || cause[0] !== 8'h80) begin n_fail++; $display("FAIL wrap_trap actual=%b/%h required=1/80", rv[0], cause[0]); end
        step();
        eret = 1; step(); eret = 0; #1;
        n_checks++; if (rv[0] !== 1'b1 || rpc[0] !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_ret actual=%b/%h required=1/fffffffc", rv[0], rpc[0]); end
        step();
    endtask

    task automatic test_irq_basic();
        write_gie(1'b1);
        write_mask(4'b0101);
        irq = 4'b0100; step();
        irq = 4'b0000; ib = 1; pc = 32'h40; #1;
        n_checks++; if (ack[0] !== 4'b0100) begin n_fail++; $display("FAIL basic_ack actual=%b required=0100", ack[0]); end
        step(); ib = 0; #1;
        n_checks++; if (rv[0] !== 1'b1 || rpc[0] !== HADDR) begin n_fail++; $display("FAIL basic_redirect actual=%b/%h required=1/%h", rv[0], rpc[0], HADDR); end
        n_checks++; if (epc[0] !== 32'h40 || cause[0] !== 8'h02) begin n_fail++; $display("FAIL basic_epc_cause actual=%h/%h required=40/02", epc[0], cause[0]); end
        n_checks++; if (pend[0] !== 4'h0) begin n_fail++; $display("FAIL basic_pend_clr actual=%b required=0000", pend[0]); end
        step(); #1;
        n_checks++; if (rv[0] !== 1'b0 || inh[0] !== 1'b1) begin n_fail++; $display("FAIL basic_handler actual=%b/%b required=0/1", rv[0], inh[0]); end
        eret = 1; step(); eret = 0; #1;
        n_checks++; if (rv[0] !== 1'b1 || rpc[0] !== 32'h40) begin n_fail++; $display("FAIL basic_return actual=%b/%h required=1/40", rv[0], rpc[0]); end
        step();
    endtask

    task automatic test_priority();
        write_mask(4'hF);
        irq = 4'b1001; step();
        irq = 4'b0000; ib = 1; pc = 32'h200; #1;
        n_checks++; if (ack[0] !== 4'b0001) begin n_fail++; $display("FAIL prio_ack0 actual=%b required=0001", ack[0]); end
        step(); ib = 0; #1;
        n_checks++; if (cause[0] !== 8'h00 || pend[0] !== 4'b1000) begin n_fail++; $display("FAIL prio_first actual=%h/%b required=00/1000", cause[0], pend[0]); end
        step();
        eret = 1; step(); eret = 0; #1;
        n_checks++; if (rv[0] !== 1'b1 || rpc[0] !== 32'h200) begin n_fail++; $display("FAIL prio_return actual=%b/%h required=1/200", rv[0], rpc[0]); end
        step();
        ib = 1; pc = 32'h204; #1;
        n_checks++; if (ack[0] !== 4'b1000) begin n_fail++; $display("FAIL prio_ack3 actual=%b required=1000", ack[0]); end
        step(); ib = 0; #1;
        n_checks++; if (cause[0] !== 8'h03 || epc[0] !== 32'h204 || rv[0] !== 1'b1)
            begin n_fail++; $display("FAIL prio_second actual=%h/%h/%b required=03/204/1", cause[0], epc[0], rv[0]); end
        step();
        eret = 1; step(); eret = 0; step();
    endtask

    task automatic test_overflow();
        write_gie(1'b0);
        ovf_v = 1; ovf = 1; pc = 32'h84; #1;
        n_checks++; if (ack[0] !== 4'h0) begin n_fail++; $display("FAIL ovf_noack actual=%b required=0000", ack[0]); end
        step(); ovf_v = 0; ovf = 0; #1;
        n_checks++; if (rv[0] !== 1'b1 || epc[0] !== 32'h80 || cause[0] !== 8'h80)
            begin n_fail++; $display("FAIL ovf_trap actual=%b/%h/%h required=1/80/80", rv[0], epc[0], cause[0]); end
        step();
        ovf_v = 1; ovf = 1; irq = 4'b0001; step(); ovf_v = 0; ovf = 0; irq = 4'h0; #1;
        n_checks++; if (fat[0] !== 1'b1 || rv[0] !== 1'b0 || inh[0] !== 1'b1)
            begin n_fail++; $display("FAIL ovf_fatal actual=%b/%b/%b required=1/0/1", fat[0], rv[0], inh[0]); end
        n_checks++; if (pend[0] !== 4'b0001) begin n_fail++; $display("FAIL ovf_pend_hold actual=%b required=0001", pend[0]); end
        step(); #1;
        n_checks++; if (rv[0] !== 1'b0) begin n_fail++; $display("FAIL ovf_no_second actual=%b required=0", rv[0]); end
        // reset while still in the handler
        rst = 0; #1;
        n_checks++; if (inh[0] !== 1'b0 || pend[0] !== 4'h0 || rv[0] !== 1'b0 || fat[0] !== 1'b0)
            begin n_fail++; $display("FAIL mid_reset actual=%b/%b/%b/%b required=0/0000/0/0", inh[0], pend[0], rv[0], fat[0]); end
        n_checks++; if (rpc[0] !== HADDR) begin n_fail++; $display("FAIL mid_reset_rpc actual=%h required=%h", rpc[0], HADDR); end
        step();
        rst = 1;
    endtask

    task automatic test_mask();
        write_gie(1'b1);
        irq = 4'b0010; step();
        irq = 4'b0000; ib = 1; pc = 32'h300; #1;
        n_checks++; if (pend[0] !== 4'b0010 || ack[0] !== 4'h0) begin n_fail++; $display("FAIL mask_hold actual=%b/%b required=0010/0000", pend[0], ack[0]); end
        step(); ib = 0; #1;
        n_checks++; if (rv[0] !== 1'b0 || inh[0] !== 1'b0) begin n_fail++; $display("FAIL mask_notrap actual=%b/%b required=0/0", rv[0], inh[0]); end
        write_mask(4'b0010);
        ib = 1; pc = 32'h304; #1;
        n_checks++; if (ack[0] !== 4'b0010) begin n_fail++; $display("FAIL mask_ack actual=%b required=0010", ack[0]); end
        step(); ib = 0; #1;
        n_checks++; if (rv[0] !== 1'b1 || cause[0] !== 8'h01 || epc[0] !== 32'h304)
            begin n_fail++; $display("FAIL mask_trap actual=%b/%h/%h required=1/01/304", rv[0], cause[0], epc[0]); end
        step();
        eret = 1; step(); eret = 0; step();
    endtask

    task automatic test_level();
        irq = 4'b0010; ib = 1; pc = 32'h400; #1;
        n_checks++; if (ack[1] !== 4'b0010) begin n_fail++; $display("FAIL lvl_ack actual=%b required=0010", ack[1]); end
        step(); ib = 0; #1;
        n_checks++; if (rv[1] !== 1'b1 || cause[1] !== 8'h01) begin n_fail++; $display("FAIL lvl_trap actual=%b/%h required=1/01", rv[1], cause[1]); end
        step();
        eret = 1; step(); eret = 0; #1;
        n_checks++; if (rv[1] !== 1'b1 || rpc[1] !== 32'h400) begin n_fail++; $display("FAIL lvl_return actual=%b/%h required=1/400", rv[1], rpc[1]); end
        step();
        ib = 1; #1;
        n_checks++; if (ack[1] !== 4'b0010) begin n_fail++; $display("FAIL lvl_retake actual=%b required=0010", ack[1]); end
        step(); ib = 0; irq = 4'h0; step();
        eret = 1; step(); eret = 0; step();
        ib = 1; #1;
        n_checks++; if (ack[1] !== 4'h0 || pend[1] !== 4'h0) begin n_fail++; $display("FAIL lvl_noretake actual=%b/%b required=0000/0000", ack[1], pend[1]); end
        step(); ib = 0;
    endtask

    task automatic test_random();
        logic        e_rv;
        logic [31:0] e_rpc;
        rst = 0; step(); rst = 1;
        for (int c = 0; c < 1500; c++) begin
            rst     = ($urandom_range(99) != 0);
            irq     = irq ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            ib      = 1'($urandom_range(1));
            ovf_v   = ($urandom_range(4) == 0);
            ovf     = 1'($urandom_range(1));
            pc      = ($urandom_range(7) == 0) ? 32'h0 : ($urandom & 32'hFFFF_FFFC);
            eret    = ($urandom_range(3) == 0);
            gie_we  = ($urandom_range(7) == 0);
            gie_wd  = ($urandom_range(3) != 0);
            mask_we = ($urandom_range(7) == 0);
            mask_wd = 4'($urandom);
            if (!rst) model_reset();
            #1;
            for (int k = 0; k < 2; k++) begin
                e_rv  = (m_ph[k] == PH_TRAP) || (m_ph[k] == PH_RETURN);
                e_rpc = (m_ph[k] == PH_RETURN) ? m_epc[k] : HADDR;
                n_checks++; if (rv[k] !== e_rv) begin n_fail++; $display("FAIL rnd_rv[%0d] cyc=%0d actual=%b required=%b", k, c, rv[k], e_rv); end
                n_checks++; if (rpc[k] !== e_rpc) begin n_fail++; $display("FAIL rnd_rpc[%0d] cyc=%0d actual=%h required=%h", k, c, rpc[k], e_rpc); end
                n_checks++; if (epc[k] !== m_epc[k]) begin n_fail++; $display("FAIL rnd_epc[%0d] cyc=%0d actual=%h required=%h", k, c, epc[k], m_epc[k]); end
                n_checks++; if (cause[k] !== m_cause[k]) begin n_fail++; $display("FAIL rnd_cause[%0d] cyc=%0d actual=%h required=%h", k, c, cause[k], m_cause[k]); end
                n_checks++; if (pend[k] !== view_pend(k)) begin n_fail++; $display("FAIL rnd_pend[%0d] cyc=%0d actual=%b required=%b", k, c, pend[k], view_pend(k)); end
                n_checks++; if (ack[k] !== exp_ack(k)) begin n_fail++; $display("FAIL rnd_ack[%0d] cyc=%0d actual=%b required=%b", k, c, ack[k], exp_ack(k)); end
                n_checks++; if (inh[k] !== (m_ph[k] == PH_HANDLER)) begin n_fail++; $display("FAIL rnd_inh[%0d] cyc=%0d actual=%b required=%b", k, c, inh[k], (m_ph[k] == PH_HANDLER)); end
                n_checks++; if (fat[k] !== m_fatal[k]) begin n_fail++; $display("FAIL rnd_fatal[%0d] cyc=%0d actual=%b required=%b", k, c, fat[k], m_fatal[k]); end
            end
            step();
        end
        rst = 1; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_irq_basic();
        test_priority();
        test_overflow();
        test_mask();
        test_level();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
